// File: rtl/booth16_pkg.sv
// Shared types and helpers for the radix-16 Booth sequential multiplier.
// Holds the FSM encoding, digit recoding and digit-count helper.
package booth16_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRECOMP,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    typedef logic signed [3:0] digit_t;

    typedef struct packed {
        logic       neg;
        logic [3:0] mag;
    } recode_t;

    function automatic int digits(input int width);
        return width / 4;
    endfunction

    // win = {b[4i+3], b[4i+2], b[4i+1], b[4i], b[4i-1]}
    function automatic recode_t booth_recode(input logic [4:0] win);
        logic signed [4:0] d;
        recode_t           r;
        d     = $signed({win[4], win[4:1]}) + $signed({4'b0000, win[0]});
        r.neg = d[4];
        r.mag = d[4] ? 4'(-d) : d[3:0];
        return r;
    endfunction

endpackage

// File: rtl/csa.sv
// Bitwise 3:2 carry-save adder over WIDTH+3 bits.
// maj is returned unshifted; the caller places it one bit up.
module csa #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+2:0] a,
    input  logic [WIDTH+2:0] b,
    input  logic [WIDTH+2:0] c,
    output logic [WIDTH+2:0] sum,
    output logic [WIDTH+2:0] maj
);

    assign sum = a ^ b ^ c;
    assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/booth16_seq_ctrl.sv
// Sequential signed multiplier: one radix-16 Booth digit per cycle,
// carry-save accumulation, single carry-propagate add at the end.
module booth16_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic                 ready_out,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 valid_out,
    input  logic                 ack_in
);

    import booth16_pkg::*;

    localparam int N  = digits(WIDTH);
    localparam int XW = WIDTH + 3;
    localparam int CW = $clog2(N) + 1;

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 bprev_q;
    logic [XW-1:0]        m3_q;
    logic [XW-1:0]        m5_q;
    logic [XW-1:0]        m7_q;
    logic [XW-1:0]        sum_q;
    logic [XW-1:0]        cy_q;
    logic                 cin_q;
    logic [WIDTH-1:0]     plo_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [CW-1:0]        cnt_q;
    logic                 ready_q;
    logic                 valid_q;

    recode_t              rc;
    logic [XW-1:0]        ax;
    logic [XW-1:0]        mag_pp;
    logic [XW-1:0]        pp;
    logic [XW-1:0]        s;
    logic [XW-1:0]        mj;
    logic [XW:0]          cf;
    logic [4:0]           nib;
    logic [XW-1:0]        sum_nx;
    logic [XW-1:0]        cy_nx;
    logic [WIDTH-1:0]     hi;

    csa #(.WIDTH(WIDTH)) u_csa (
        .a   (sum_q),
        .b   (cy_q),
        .c   (pp),
        .sum (s),
        .maj (mj)
    );

    always_comb begin
        ax = {{3{a_q[WIDTH-1]}}, a_q};
        rc = booth_recode({b_q[3:0], bprev_q});
        case (rc.mag)
            4'd1:    mag_pp = ax;
            4'd2:    mag_pp = ax << 1;
            4'd3:    mag_pp = m3_q;
            4'd4:    mag_pp = ax << 2;
            4'd5:    mag_pp = m5_q;
            4'd6:    mag_pp = m3_q << 1;
            4'd7:    mag_pp = m7_q;
            4'd8:    mag_pp = ax << 3;
            default: mag_pp = '0;
        endcase
        pp = rc.neg ? ~mag_pp : mag_pp;
        // Carry kept one bit wider so the pair sums exactly, no wrap.
        cf     = {mj, rc.neg};
        nib    = {1'b0, s[3:0]} + {1'b0, cf[3:0]} + {4'b0000, cin_q};
        sum_nx = {{4{s[XW-1]}}, s[XW-1:4]};
        cy_nx  = {{3{cf[XW]}}, cf[XW:4]};
        hi     = sum_q[WIDTH-1:0] + cy_q[WIDTH-1:0] + WIDTH'(cin_q);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bprev_q <= 1'b0;
            m3_q    <= '0;
            m5_q    <= '0;
            m7_q    <= '0;
            sum_q   <= '0;
            cy_q    <= '0;
            cin_q   <= 1'b0;
            plo_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_q     <= multiplicand_in;
                        b_q     <= multiplier_in;
                        ready_q <= 1'b0;
                        state   <= PRECOMP;
                    end
                end
                PRECOMP: begin
                    m3_q    <= ax + (ax << 1);
                    m5_q    <= ax + (ax << 2);
                    m7_q    <= (ax << 3) - ax;
                    sum_q   <= '0;
                    cy_q    <= '0;
                    cin_q   <= 1'b0;
                    plo_q   <= '0;
                    bprev_q <= 1'b0;
                    cnt_q   <= '0;
                    state   <= ACCUM;
                end
                ACCUM: begin
                    sum_q   <= sum_nx;
                    cy_q    <= cy_nx;
                    cin_q   <= nib[4];
                    plo_q   <= {nib[3:0], plo_q[WIDTH-1:4]};
                    bprev_q <= b_q[3];
                    b_q     <= {4'b0000, b_q[WIDTH-1:4]};
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    prod_q  <= {hi, plo_q};
                    valid_q <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (ack_in) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ready_out   = ready_q;
    assign valid_out   = valid_q;
    assign product_out = prod_q;

endmodule

// File: doc/booth16_seq_ctrl.md
BOOTH16_SEQ_CTRL -- requirements
Module: booth16_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start_in, input, 1 bit: request a new multiplication.
REQ-005 The block SHALL have port ready_out, output, 1 bit: high only in IDLE; start_in is accepted when start_in && ready_out.
REQ-006 The block SHALL have port multiplicand_in, input, WIDTH bits: signed two's-complement operand A, sampled on acceptance.
REQ-007 The block SHALL have port multiplier_in, input, WIDTH bits: signed two's-complement operand B, sampled on acceptance.
REQ-008 The block SHALL have port product_out, output, 2*WIDTH bits: signed product A*B.
REQ-009 The block SHALL have port valid_out, output, 1 bit: product_out is valid.
REQ-010 The block SHALL have port ack_in, input, 1 bit: consumer takes the result when valid_out && ack_in.

Function
REQ-011 The FSM SHALL have states IDLE, PRECOMP, ACCUM, RESOLVE and DONE.
REQ-012 On acceptance, the block SHALL register A and B and go IDLE->PRECOMP; start_in is ignored in every state other than IDLE.
REQ-013 PRECOMP (1 cycle) SHALL register hard multiples 3A, 5A and 7A, sign-extended to WIDTH+3 bits, clear the sum/carry accumulators and the digit counter, then go to ACCUM.
REQ-014 ACCUM SHALL last N = WIDTH/4 cycles; in cycle i (i = 0..N-1) it SHALL Booth-recode digit d_i = -8*b[4i+3] + 4*b[4i+2] + 2*b[4i+1] + b[4i] + b[4i-1], with b[-1] = 0 and d_i in -8..+8.
REQ-015 In ACCUM, the partial product SHALL be |d_i|*A selected from {0, A, 2A, 3A, 4A, 5A, 6A, 7A, 8A}, with even multiples formed by shifts and negation by inversion plus a carry-in LSB injected into the carry vector.
REQ-016 The partial product SHALL be combined with the sum/carry accumulators through one WIDTH+3-bit carry-save adder; the retired low 4 bits SHALL shift into the product low register each cycle, and the upper bits SHALL be arithmetically shifted right by 4.
REQ-017 After the N-th ACCUM cycle the FSM SHALL go to RESOLVE, which (1 cycle) carry-propagate adds sum and carry into the upper WIDTH bits of the product register.
REQ-018 RESOLVE SHALL go to DONE, where valid_out = 1 and product_out is held stable until valid_out && ack_in.
REQ-019 On valid_out && ack_in, the FSM SHALL go DONE->IDLE, clearing valid_out in the next cycle; product_out retains its last value in IDLE.
REQ-020 Latency SHALL be exactly N+3 cycles from the accepting edge to the first cycle with valid_out = 1 (WIDTH=8: 5 cycles).
REQ-021 The block SHALL handle extreme operands exactly with no overflow: A = B = -2^(WIDTH-1) gives +2^(2*WIDTH-2).
REQ-022 ack_in asserted while not in DONE SHALL have no effect.

Reset
REQ-023 When rst_in = 1 at a rising edge, the FSM SHALL go to IDLE in any state, including mid-ACCUM, and the operation in flight SHALL be discarded.
REQ-024 Reset values SHALL be: ready_out = 1 (from IDLE), valid_out = 0, product_out = 0, accumulators, multiples and digit counter = 0.
REQ-025 start_in sampled in the same edge as rst_in = 1 SHALL be ignored.

Structure
REQ-026 A shared package booth16_pkg SHALL hold the state enum, the 4-bit signed digit type, the DIGITS = WIDTH/4 constant function, and a pure function recoding 5 multiplier bits into {negate, magnitude}.
REQ-027 The carry-save adder SHALL be the existing csa module instantiated once with the same WIDTH; no other sub-module is needed.

Verification
REQ-028 WIDTH=8: A = 7, B = 3 -> product_out = 21 with valid_out high exactly 5 cycles after acceptance.
REQ-029 WIDTH=8: A = -128, B = -128 -> 16384; A = -128, B = 127 -> -16256; A = 0, B = -1 -> 0.
REQ-030 WIDTH=8: start_in pulsed again during ACCUM with different operands -> ignored; first result is unchanged and ready_out stays 0 until the return to IDLE.
REQ-031 WIDTH=8: ack_in held low for 10 cycles in DONE -> valid_out and product_out remain stable; after ack_in, ready_out = 1 in the next cycle.
REQ-032 WIDTH=8: rst_in asserted in the second ACCUM cycle -> next cycle shows IDLE, ready_out = 1, valid_out = 0, product_out = 0; a new 5*(-6) then yields -30.
REQ-033 WIDTH=16: random signed operand sweep of at least 10k vectors checked against a reference model.
